instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
// Instruction fetch controller: owns the program counter, reads a
// combinational instruction memory and queues {pc, instruction} pairs in
// a small FIFO that decode drains with a valid/ready handshake.
//
// Parameters
//   RESET_PC  PC value loaded while rst_n is low
//   DEPTH     fetch-buffer entries (2..8)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   fetch_en                 fetching permitted while high
//   halt                     stop fetching, enter HALTED
//   redirect_valid/_pc       branch/jump redirect (target is halfword-aligned)
//   pc_addr                  address to instruction memory (the PC)
//   instr_in                 instruction read data for pc_addr
//   out_valid/ready          handshake toward decode
//   out_instr/out_pc         head entry of the fetch buffer
//   state_o                  00 IDLE, 01 FETCH, 10 HALTED
//   stall_cnt                (FETCH_PERF_EN only) saturating count of FETCH
//                            cycles lost to a full buffer with no pop
//
// Optional feature macro: FETCH_PERF_EN
module instr_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc_addr,
  input  logic [15:0] instr_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [1:0]  state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    pc, pc_nxt;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [15:0]    buf_instr [DEPTH];
  logic [15:0]    buf_pc    [DEPTH];
  logic           full, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // Redirect and halt both suppress the fetch; a full buffer can still
  // accept when the head leaves in the same cycle.
  assign push      = (state == FETCH) & fetch_en & ~halt & ~redirect_valid
                   & (~full | pop);

  assign pc_addr   = pc;
  assign state_o   = state;
  assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (!fetch_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        // Redirect outranks halt, so a simultaneous pair keeps fetching.
        FETCH:   if (!redirect_valid && halt) state_nxt = HALTED;
        HALTED:  if (redirect_valid) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
    if (redirect_valid)
      pc_nxt = {redirect_pc[15:1], 1'b0};
    else if (push)
      pc_nxt = pc + 16'd2;  // wraps modulo 2^16
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle pop.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= instr_in;
      buf_pc[wr_ptr]    <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == FETCH && full && !pop && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc_addr;
  logic [15:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [1:0]  state_o;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  instr_fetch_ctrl #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_addr        (pc_addr),
    .instr_in       (instr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
    .stall_cnt      (stall_cnt),
`endif
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: word n holds value n.
  assign instr_in = pc_addr >> 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [15:0] pc);
    exp_q.push_back({pc, pc >> 1});
  endtask

  task automatic check_drained(input string name);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: each accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {out_pc, out_instr}, 32'hxxxx_xxxx);
      end else begin
        check("delivery", {out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    step(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_pc_addr", 32'(pc_addr), 32'd0);

    // Streaming fetch with decode always ready.
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    expect_entry(16'h0000); expect_entry(16'h0002);
    expect_entry(16'h0004); expect_entry(16'h0006);
    step(1);
    check("stream_state_fetch", 32'(state_o), 32'd1);
    check("stream_first_latency", 32'(out_valid), 32'd0);
    step(4);
    fetch_en = 1'b0;
    step(3);
    check("stream_idle", 32'(state_o), 32'd0);
    check("stream_pc_hold", 32'(pc_addr), 32'h0008);
    check("stream_empty", 32'(out_valid), 32'd0);
    check_drained("stream");

    // Fill, then reset mid-operation.
    fetch_en = 1'b1; out_ready = 1'b0;
    step(4);
    check("prerst_full_pc", 32'(out_pc), 32'h0008);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pc", 32'(pc_addr), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;

    // Backpressure: buffer fills, PC freezes at 4.
    step(4);
    check("bp_pc_freeze", 32'(pc_addr), 32'h0004);
    check("bp_head", {16'(out_valid), out_pc}, {16'd1, 16'h0000});
    step(2);
    check("bp_pc_still", 32'(pc_addr), 32'h0004);
    expect_entry(16'h0000); expect_entry(16'h0002);
    out_ready = 1'b1; fetch_en = 1'b0;
    step(3);
    check("bp_empty", 32'(out_valid), 32'd0);
    check_drained("bp");

    // Redirect while full.
    fetch_en = 1'b1; out_ready = 1'b0;
    step(3);
    check("rd_full_head", 32'(out_pc), 32'h0004);
    redirect_valid = 1'b1; redirect_pc = 16'h000B;
    step(1);
    redirect_valid = 1'b0;
    check("rd_valid_low", 32'(out_valid), 32'd0);
    check("rd_pc_aligned", 32'(pc_addr), 32'h000A);
    step(1);
    check("rd_first_entry", {16'(out_valid), out_pc, out_instr}, {16'd1, 16'h000A, 16'h0005});

    // Redirect and halt together: redirect wins.
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step(1);
    redirect_valid = 1'b0; halt = 1'b0;
    check("rh_state", 32'(state_o), 32'd1);
    check("rh_pc", 32'(pc_addr), 32'h0040);
    check("rh_flush", 32'(out_valid), 32'd0);
    step(1);
    halt = 1'b1;
    step(1);
    check("halt_state", 32'(state_o), 32'd2);
    check("halt_pc", 32'(pc_addr), 32'h0042);
    expect_entry(16'h0040);
    out_ready = 1'b1;
    step(2);
    check("halt_pc_hold", 32'(pc_addr), 32'h0042);
    check("halt_state_hold", 32'(state_o), 32'd2);
    check("halt_drained", 32'(out_valid), 32'd0);
    check_drained("halt");

    // Leave HALTED through a redirect to the top of memory; PC wraps.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE; halt = 1'b0; out_ready = 1'b0;
    step(1);
    redirect_valid = 1'b0;
    check("wrap_state", 32'(state_o), 32'd1);
    step(2);
    check("wrap_pc", 32'(pc_addr), 32'h0002);
    expect_entry(16'hFFFE); expect_entry(16'h0000);
    out_ready = 1'b1; fetch_en = 1'b0;
    step(3);
    check_drained("wrap");

`ifdef FETCH_PERF_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    fetch_en = 1'b1; out_ready = 1'b0;
    step(3);
    step(5);
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    check("stall_cnt_rst", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
